// File: rtl/polar_sc_decode_if.sv
// polar_sc_decode_if: codeword-in / decoded-word-out handshake bundle for the SC polar decoder
interface polar_sc_decode_if #(
    parameter int N = 16,
    parameter int W = 6
) ();
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_llr;
    logic [0:N-1]   frozen_mask;
    logic           out_valid;
    logic           out_ready;
    logic [0:N-1]   out_u;
    modport master (output in_valid, in_llr, frozen_mask, out_ready, input in_ready, out_valid, out_u);
    modport slave  (input in_valid, in_llr, frozen_mask, out_ready, output in_ready, out_valid, out_u);
endinterface

// File: rtl/polar_sc_decode.sv
// polar_sc_decode: successive-cancellation hard-output decoder for natural-order polar codes
module polar_sc_decode #(
    parameter int N = 16,
    parameter int W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    polar_sc_decode_if.slave bus
);
    localparam int M  = $clog2(N);
    localparam int LW = $clog2(M + 1);
    localparam logic signed [W-1:0] LMAX = W'((1 << (W - 1)) - 1);
    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_DONE} state_t;
    state_t r_state, w_next;
    // r_llr[k] holds the LLRs of the active node of length 2^k; level M is the channel word
    logic signed [W-1:0] r_llr [0:M][0:N-1];
    // r_ps[k] holds the re-encoded bits of the most recently completed node of length 2^k
    logic [0:N-1]        r_ps  [0:M];
    logic [0:N-1]        w_ps  [0:M-1];
    logic signed [W-1:0] w_in  [0:N-1];
    logic signed [W-1:0] w_child [0:N/2-1];
    logic [0:N-1]        r_mask, r_out_u;
    logic [LW-1:0]       r_lvl, w_tz;
    logic [M-1:0]        r_bit, w_nxt, w_half;
    logic                r_op_g, r_fin, w_u;
    // channel LLRs: the most negative code is folded onto the symmetric range
    for (genvar i = 0; i < N; i++) begin : g_in
        logic signed [W-1:0] w_raw;
        assign w_raw   = bus.in_llr[(N-1-i)*W +: W];
        assign w_in[i] = (w_raw[W-1] && w_raw[W-2:0] == '0) ? -LMAX : w_raw;
    end
    assign w_half = M'(1) << (r_lvl - LW'(1));
    // stage-parallel min-sum array: f or g over the whole active node in one cycle
    for (genvar j = 0; j < N / 2; j++) begin : g_pe
        logic [M-1:0]        w_idx;
        logic signed [W-1:0] w_a, w_b, w_abs_a, w_abs_b, w_min, w_f, w_g;
        logic signed [W:0]   w_ax, w_bx, w_sum;
        assign w_idx      = M'(j) + w_half;
        assign w_a        = r_llr[r_lvl][j];
        assign w_b        = r_llr[r_lvl][w_idx];
        assign w_abs_a    = w_a[W-1] ? -w_a : w_a;
        assign w_abs_b    = w_b[W-1] ? -w_b : w_b;
        assign w_min      = (w_abs_a < w_abs_b) ? w_abs_a : w_abs_b;
        assign w_f        = (w_a[W-1] ^ w_b[W-1]) ? -w_min : w_min;
        assign w_ax       = (W+1)'(w_a);
        assign w_bx       = (W+1)'(w_b);
        assign w_sum      = w_bx + (r_ps[r_lvl - LW'(1)][j] ? -w_ax : w_ax);
        assign w_g        = (w_sum > (W+1)'(LMAX)) ? LMAX : (w_sum < -(W+1)'(LMAX)) ? -LMAX : w_sum[W-1:0];
        assign w_child[j] = r_op_g ? w_g : w_f;
    end
    assign w_u   = ~r_mask[r_bit] & w_child[0][W-1];
    assign w_nxt = r_bit + M'(1);
    // next bit restarts with a g step at the level of its lowest set index bit
    always_comb begin
        w_tz = '0;
        for (int k = M - 1; k >= 0; k--) if (w_nxt[k]) w_tz = LW'(k);
    end
    // partial-sum cascade: each completed right child folds its left sibling into the parent
    always_comb begin
        w_ps[0]    = '0;
        w_ps[0][0] = w_u;
        for (int k = 1; k < M; k++) begin
            w_ps[k] = '0;
            for (int j = 0; j < (1 << (k - 1)); j++) begin
                w_ps[k][j]                  = r_ps[k-1][j] ^ w_ps[k-1][j];
                w_ps[k][j + (1 << (k - 1))] = w_ps[k-1][j];
            end
        end
    end
    // datapath: load on accept, then one f/g step per cycle with leaf decisions on length-2 steps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= M; k++) begin
                r_ps[k] <= '0;
                for (int j = 0; j < N; j++) r_llr[k][j] <= '0;
            end
            r_mask  <= '0;
            r_out_u <= '0;
            r_lvl   <= '0;
            r_bit   <= '0;
            r_op_g  <= 1'b0;
            r_fin   <= 1'b0;
        end else if (r_state == S_IDLE && bus.in_valid) begin
            for (int j = 0; j < N; j++) r_llr[M][j] <= w_in[j];
            r_mask  <= bus.frozen_mask;
            r_out_u <= '0;
            r_lvl   <= LW'(M);
            r_bit   <= '0;
            r_op_g  <= 1'b0;
            r_fin   <= 1'b0;
        end else if (r_state == S_DECODE && !r_fin) begin
            for (int k = 0; k < M; k++)
                for (int j = 0; j < N / 2; j++)
                    if (LW'(k + 1) == r_lvl && M'(j) < w_half) r_llr[k][j] <= w_child[j];
            if (r_lvl == LW'(1)) begin
                r_out_u[r_bit] <= w_u;
                for (int k = 0; k < M; k++)
                    if ((r_bit & M'((1 << k) - 1)) == M'((1 << k) - 1)) r_ps[k] <= w_ps[k];
                r_bit  <= w_nxt;
                r_fin  <= &r_bit;
                r_lvl  <= w_tz + LW'(1);
                r_op_g <= 1'b1;
            end else begin
                r_lvl  <= r_lvl - LW'(1);
                r_op_g <= 1'b0;
            end
        end
    end
    // control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end
    // next state and handshake outputs; DECODE holds one wrap-up cycle after the last step
    always_comb begin
        w_next        = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_next = S_DECODE;
            end
            S_DECODE: if (r_fin) w_next = S_DONE;
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
    assign bus.out_u = r_out_u;
endmodule
